riscv_dmem_resp: RTL

- Data-memory responder serving the pipeline's memory-stage load/store requests.
- Accepts one request at a time over a valid/ready handshake and applies byte-lane writes to an internal word array.
- Returns the read word, or a write acknowledge, after a programmable latency over a valid/ready response channel.
- Sits between the memory pipeline stage (initiator) and the writeback result mux.

---
 rtl/riscv_configs_pkg.sv | 32 +++
 rtl/riscv_dmem_array.sv | 38 +++
 rtl/riscv_dmem_resp.sv | 124 ++++++++++++
 3 files changed

// File: rtl/riscv_configs_pkg.sv
// Shared configuration for the data-memory responder: XLEN, FSM encodings, byte-select constants.
// The misalignment check helper is used only when RISCV_DMEM_MISALIGN_CHK_EN is defined.
`ifndef XLEN
`define XLEN 32
`endif

package riscv_configs;

    localparam int XLEN = `XLEN;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_t;

    localparam logic [3:0] BSEL_WORD    = 4'b1111;
    localparam logic [3:0] BSEL_HALF_LO = 4'b0011;
    localparam logic [3:0] BSEL_HALF_HI = 4'b1100;

    // Word accesses need addr[1:0]==0, halfword accesses need addr[0]==0.
    function automatic logic is_misaligned(input logic [3:0] bsel, input logic [1:0] lsb);
        logic w_mis;
        w_mis = 1'b0;
        if (bsel == BSEL_WORD && lsb != 2'b00)
            w_mis = 1'b1;
        if ((bsel == BSEL_HALF_LO || bsel == BSEL_HALF_HI) && lsb[0])
            w_mis = 1'b1;
        return w_mis;
    endfunction

endpackage

// File: rtl/riscv_dmem_array.sv
// Synchronous single-port RAM with per-byte write enables; the read register
// only updates on a read access so it holds the last loaded word.
`ifndef XLEN
`define XLEN 32
`endif

module riscv_dmem_array #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               i_clk,
    input  logic               i_en,
    input  logic               i_we,
    input  logic [3:0]         i_be,
    input  logic [AW-1:0]      i_addr,
    input  logic [`XLEN-1:0]   i_wdata,
    output logic [`XLEN-1:0]   o_rdata
);

    logic [`XLEN-1:0] r_mem [DEPTH];
    logic [`XLEN-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            if (i_we) begin
                for (int k = 0; k < 4; k++) begin
                    if (i_be[k])
                        r_mem[i_addr][8*k +: 8] <= i_wdata[8*k +: 8];
                end
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/riscv_dmem_resp.sv
// Data-memory responder: one outstanding load/store, response after LATENCY cycles.
// Define RISCV_DMEM_MISALIGN_CHK_EN to flag and suppress misaligned accesses.
`ifndef XLEN
`define XLEN 32
`endif

module riscv_dmem_resp
    import riscv_configs::*;
#(
    parameter int DMEM_DEPTH = 1024,
    parameter int LATENCY    = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_req_valid,
    output logic               o_req_ready,
    input  logic               i_req_wr_en,
    input  logic [3:0]         i_req_byte_sel,
    input  logic [`XLEN-1:0]   i_req_addr,
    input  logic [`XLEN-1:0]   i_req_wdata,
    output logic               o_rsp_valid,
    input  logic               i_rsp_ready,
    output logic [`XLEN-1:0]   o_rsp_rdata,
    output logic               o_rsp_err
);

    localparam int          AW       = $clog2(DMEM_DEPTH);
    localparam logic [3:0]  CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
    localparam dmem_state_t ST_START = (LATENCY > 1) ? ST_BUSY : ST_RESP;

    dmem_state_t      r_state, w_state_nxt;
    logic [3:0]       r_cnt, w_cnt_nxt;
    logic             r_ld_ok;
    logic             w_accept;
    logic             w_mis;
    logic             w_ram_en;
    logic [`XLEN-1:0] w_ram_rdata;
    logic             w_unused_addr;

    assign o_req_ready = (r_state == ST_IDLE) || (r_state == ST_RESP && i_rsp_ready);
    assign w_accept    = i_req_valid && o_req_ready;

`ifdef RISCV_DMEM_MISALIGN_CHK_EN
    logic r_err;

    assign w_mis = is_misaligned(i_req_byte_sel, i_req_addr[1:0]);

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_err <= 1'b0;
        else if (w_accept)
            r_err <= w_mis;
    end

    assign o_rsp_err = (r_state == ST_RESP) && r_err;
`else
    assign w_mis     = 1'b0;
    assign o_rsp_err = 1'b0;
`endif

    // Upper bits wrap; low bits only matter to the misalignment check.
    assign w_unused_addr = ^{i_req_addr[`XLEN-1:AW+2], i_req_addr[1:0]};

    // A request arriving during reset must not touch the array.
    assign w_ram_en = w_accept && !w_mis && !i_rst;

    riscv_dmem_array #(
        .DEPTH (DMEM_DEPTH)
    ) u_array (
        .i_clk   (i_clk),
        .i_en    (w_ram_en),
        .i_we    (i_req_wr_en),
        .i_be    (i_req_byte_sel),
        .i_addr  (i_req_addr[AW+1:2]),
        .i_wdata (i_req_wdata),
        .o_rdata (w_ram_rdata)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_START;
                    w_cnt_nxt   = CNT_INIT;
                end
            end
            ST_BUSY: begin
                if (r_cnt == 4'd0)
                    w_state_nxt = ST_RESP;
                else
                    w_cnt_nxt = r_cnt - 4'd1;
            end
            ST_RESP: begin
                if (w_accept) begin
                    w_state_nxt = ST_START;
                    w_cnt_nxt   = CNT_INIT;
                end else if (i_rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_ld_ok <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept)
                r_ld_ok <= !i_req_wr_en && !w_mis;
        end
    end

    assign o_rsp_valid = (r_state == ST_RESP);
    // Stores and suppressed loads report zero data.
    assign o_rsp_rdata = (o_rsp_valid && r_ld_ok) ? w_ram_rdata : '0;

endmodule
